// File: rtl/typedef_pkg.sv
// Shared types for the retirement stage: ROB entry layout, retire FSM states
// and the default retire width.
package typedef_pkg;

    localparam int RETIRE_WIDTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        exception;
        logic        rd_valid;
        logic [4:0]  rd_arch;
        logic [6:0]  pd_new;
        logic [6:0]  pd_old;
        logic [3:0]  exc_cause;
        logic        is_store;
    } ROB_ENTRY_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } RETIRE_STATE_t;

endpackage

// File: rtl/rob_status_if.sv
// Status view of the reorder buffer; the retire unit sits on the sink side
// and hands back how many head entries it consumed this cycle.
interface rob_status_if #(
    parameter int NUM_ROB_ENTRY = 32,
    parameter int ROB_WIDTH     = 5
);
    logic [NUM_ROB_ENTRY-1:0] rob_finish;
    typedef_pkg::ROB_ENTRY_t  rob [NUM_ROB_ENTRY];
    logic [NUM_ROB_ENTRY-1:0] rob_head;
    logic                     rob_full;
    logic                     rob_empty;
    logic [ROB_WIDTH-1:0]     retire_num;

    modport sink   (input rob_finish, rob, rob_head, rob_full, rob_empty, output retire_num);
    modport source (output rob_finish, rob, rob_head, rob_full, rob_empty, input retire_num);
endinterface

// File: rtl/retire_select.sv
// Combinational scan of up to RETIRE_WIDTH ROB entries from the head: counts
// the leading finished, exception-free entries and reports a blocking exception.
module retire_select
    import typedef_pkg::*;
#(
    parameter int NUM_ROB_ENTRY = 32,
    parameter int ROB_WIDTH     = 5,
    parameter int RETIRE_WIDTH  = RETIRE_WIDTH_DEFAULT
) (
    input  RETIRE_STATE_t                         state_i,
    input  logic                                  rob_empty_i,
    input  logic [ROB_WIDTH-1:0]                  head_idx_i,
    input  logic [NUM_ROB_ENTRY-1:0]              rob_finish_i,
    input  logic [NUM_ROB_ENTRY-1:0]              rob_exc_i,
    output logic [RETIRE_WIDTH-1:0][ROB_WIDTH-1:0] slot_idx_o,
    output logic [ROB_WIDTH-1:0]                  count_o,
    output logic                                  exc_valid_o,
    output logic [ROB_WIDTH-1:0]                  exc_idx_o
);

    logic stop_s;

    // ROB entry examined by each slot, wrapping past the last entry
    always_comb begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            slot_idx_o[k] = ROB_WIDTH'((int'(head_idx_i) + k) % NUM_ROB_ENTRY);
        end
    end

    // In-order scan: the first unfinished or excepting slot ends retirement
    always_comb begin
        count_o     = '0;
        exc_valid_o = 1'b0;
        exc_idx_o   = '0;
        stop_s      = (state_i != RUN) || rob_empty_i;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (!stop_s && rob_finish_i[slot_idx_o[k]]) begin
                if (rob_exc_i[slot_idx_o[k]]) begin
                    exc_valid_o = 1'b1;
                    exc_idx_o   = slot_idx_o[k];
                    stop_s      = 1'b1;
                end else begin
                    count_o = count_o + ROB_WIDTH'(1);
                end
            end else begin
                stop_s = 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_unit_chk.sv
// Simulation checks on the ROB status seen by the retire unit.
module retire_unit_chk #(
    parameter int NUM_ROB_ENTRY = 32
) (
    input logic                     clk,
    input logic                     rst,
    input logic [NUM_ROB_ENTRY-1:0] rob_head_i
);

    a_head_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(rob_head_i))
        else $error("rob_head is not one-hot: %b", rob_head_i);

endmodule

// File: rtl/retire_unit.sv
// In-order retirement: drives retire_num back to the ROB, registers commit
// records, counts retired instructions and sequences exception flush/redirect.
module retire_unit
    import typedef_pkg::*;
#(
    parameter int NUM_ROB_ENTRY = 32,
    parameter int ROB_WIDTH     = 5,
    parameter int RETIRE_WIDTH  = RETIRE_WIDTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    rob_status_if.sink                         rob_status,
    output logic       [RETIRE_WIDTH-1:0]      commit_valid,
    output ROB_ENTRY_t [RETIRE_WIDTH-1:0]      commit_entry,
    output logic                               flush,
    output logic       [31:0]                  redirect_pc,
    output logic       [63:0]                  instret
);

    logic [ROB_WIDTH-1:0]                   head_idx_s;
    logic [NUM_ROB_ENTRY-1:0]               rob_exc_s;
    logic [RETIRE_WIDTH-1:0][ROB_WIDTH-1:0] slot_idx_s;
    logic [ROB_WIDTH-1:0]                   sel_count_s;
    logic                                   exc_valid_s;
    logic [ROB_WIDTH-1:0]                   exc_idx_s;

    RETIRE_STATE_t                  state_q, state_d;
    logic [RETIRE_WIDTH-1:0]        commit_valid_q, commit_valid_d;
    ROB_ENTRY_t [RETIRE_WIDTH-1:0]  commit_entry_q, commit_entry_d;
    logic                           flush_q, flush_d;
    logic [31:0]                    redirect_pc_q, redirect_pc_d;
    logic [63:0]                    instret_q, instret_d;

    // Head pointer to index; scanning downward makes the lowest set bit win
    always_comb begin
        head_idx_s = '0;
        for (int i = NUM_ROB_ENTRY - 1; i >= 0; i--) begin
            head_idx_s = rob_status.rob_head[i] ? ROB_WIDTH'(i) : head_idx_s;
        end
    end

    // Gather exception flags into a flat vector for the selector
    always_comb begin
        for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
            rob_exc_s[i] = rob_status.rob[i].exception;
        end
    end

    retire_select #(
        .NUM_ROB_ENTRY (NUM_ROB_ENTRY),
        .ROB_WIDTH     (ROB_WIDTH),
        .RETIRE_WIDTH  (RETIRE_WIDTH)
    ) u_select (
        .state_i      (state_q),
        .rob_empty_i  (rob_status.rob_empty),
        .head_idx_i   (head_idx_s),
        .rob_finish_i (rob_status.rob_finish),
        .rob_exc_i    (rob_exc_s),
        .slot_idx_o   (slot_idx_s),
        .count_o      (sel_count_s),
        .exc_valid_o  (exc_valid_s),
        .exc_idx_o    (exc_idx_s)
    );

    assign rob_status.retire_num = rst ? '0 : sel_count_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = exc_valid_s ? FLUSH : RUN;
            FLUSH:   state_d = DRAIN;
            DRAIN:   state_d = rob_status.rob_empty ? RUN : DRAIN;
            default: state_d = RUN;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        flush_d       = (state_d == FLUSH);
        redirect_pc_d = exc_valid_s ? rob_status.rob[exc_idx_s].pc : redirect_pc_q;
        instret_d     = instret_q + 64'(sel_count_s);
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            commit_valid_d[k] = (k < int'(sel_count_s));
            commit_entry_d[k] = rob_status.rob[slot_idx_s[k]];
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid_q <= '0;
            commit_entry_q <= '0;
            flush_q        <= 1'b0;
            redirect_pc_q  <= 32'd0;
            instret_q      <= 64'd0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_entry_q <= commit_entry_d;
            flush_q        <= flush_d;
            redirect_pc_q  <= redirect_pc_d;
            instret_q      <= instret_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_entry = commit_entry_q;
    assign flush        = flush_q;
    assign redirect_pc  = redirect_pc_q;
    assign instret      = instret_q;

    retire_unit_chk #(.NUM_ROB_ENTRY(NUM_ROB_ENTRY)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .rob_head_i (rob_status.rob_head)
    );

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: ROB status is driven by hand and every
// expected value below is worked out from the ROB contents set up in init_rob.
module tb_retire_unit;
    import typedef_pkg::*;

    logic                         clk;
    logic                         rst;
    logic [3:0]                   commit_valid;
    ROB_ENTRY_t [3:0]             commit_entry;
    logic                         flush;
    logic [31:0]                  redirect_pc;
    logic [63:0]                  instret;

    int n_total = 0;
    int n_pass  = 0;

    rob_status_if #(.NUM_ROB_ENTRY(32), .ROB_WIDTH(5)) rs ();

    retire_unit #(.NUM_ROB_ENTRY(32), .ROB_WIDTH(5), .RETIRE_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rob_status   (rs.sink),
        .commit_valid (commit_valid),
        .commit_entry (commit_entry),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .instret      (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // entry i: pc = 0x1000 + 4*i, rd_arch = i, pd_new = i + 32, pd_old = i
    task automatic init_rob();
        for (int i = 0; i < 32; i++) begin
            rs.rob[i].pc        = 32'h0000_1000 + 32'(4 * i);
            rs.rob[i].exception = 1'b0;
            rs.rob[i].rd_valid  = 1'b1;
            rs.rob[i].rd_arch   = 5'(i);
            rs.rob[i].pd_new    = 7'(i + 32);
            rs.rob[i].pd_old    = 7'(i);
            rs.rob[i].exc_cause = 4'(i);
            rs.rob[i].is_store  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_rob();
        rs.rob_head   = 32'h0000_0001;
        rs.rob_finish = 32'hFFFF_FFFF;
        rs.rob_empty  = 1'b0;
        rs.rob_full   = 1'b0;
        #1;
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL reset_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        step();
        n_total++; if (commit_valid !== 4'b0000) $display("FAIL reset_commit_valid: got %b expected 0000", commit_valid); else n_pass++;
        n_total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b expected 0", flush); else n_pass++;
        n_total++; if (instret !== 64'd0) $display("FAIL reset_instret: got %0d expected 0", instret); else n_pass++;
        n_total++; if (redirect_pc !== 32'd0) $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); else n_pass++;
        rs.rob_finish = 32'h0000_0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_four_finished();
        rs.rob_head   = 32'h0000_0008;
        rs.rob_finish = 32'h0000_0078;
        #1;
        n_total++; if (rs.retire_num !== 5'd4) $display("FAIL four_retire_num: got %0d expected 4", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        n_total++; if (commit_valid !== 4'b1111) $display("FAIL four_commit_valid: got %b expected 1111", commit_valid); else n_pass++;
        n_total++; if (commit_entry[0].pc !== 32'h0000_100C) $display("FAIL four_slot0_pc: got %h expected 0000100c", commit_entry[0].pc); else n_pass++;
        n_total++; if (commit_entry[1].pc !== 32'h0000_1010) $display("FAIL four_slot1_pc: got %h expected 00001010", commit_entry[1].pc); else n_pass++;
        n_total++; if (commit_entry[2].pc !== 32'h0000_1014) $display("FAIL four_slot2_pc: got %h expected 00001014", commit_entry[2].pc); else n_pass++;
        n_total++; if (commit_entry[3].rd_arch !== 5'd6) $display("FAIL four_slot3_rd_arch: got %0d expected 6", commit_entry[3].rd_arch); else n_pass++;
        n_total++; if (commit_entry[0].pd_new !== 7'd35) $display("FAIL four_slot0_pd_new: got %0d expected 35", commit_entry[0].pd_new); else n_pass++;
        n_total++; if (commit_entry[0].pd_old !== 7'd3) $display("FAIL four_slot0_pd_old: got %0d expected 3", commit_entry[0].pd_old); else n_pass++;
        n_total++; if (instret !== 64'd4) $display("FAIL four_instret: got %0d expected 4", instret); else n_pass++;
        step();
        n_total++; if (commit_valid !== 4'b0000) $display("FAIL four_idle_commit_valid: got %b expected 0000", commit_valid); else n_pass++;
    endtask

    task automatic test_gap();
        rs.rob_head   = 32'h0000_0400;
        rs.rob_finish = 32'h0000_2C00;
        #1;
        n_total++; if (rs.retire_num !== 5'd2) $display("FAIL gap_retire_num: got %0d expected 2", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        n_total++; if (commit_valid !== 4'b0011) $display("FAIL gap_commit_valid: got %b expected 0011", commit_valid); else n_pass++;
        n_total++; if (commit_entry[1].pc !== 32'h0000_102C) $display("FAIL gap_slot1_pc: got %h expected 0000102c", commit_entry[1].pc); else n_pass++;
        n_total++; if (instret !== 64'd6) $display("FAIL gap_instret: got %0d expected 6", instret); else n_pass++;
    endtask

    task automatic test_wrap();
        rs.rob_head   = 32'h4000_0000;
        rs.rob_finish = 32'hC000_0003;
        #1;
        n_total++; if (rs.retire_num !== 5'd4) $display("FAIL wrap_retire_num: got %0d expected 4", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        n_total++; if (commit_entry[0].pc !== 32'h0000_1078) $display("FAIL wrap_slot0_pc: got %h expected 00001078", commit_entry[0].pc); else n_pass++;
        n_total++; if (commit_entry[1].pc !== 32'h0000_107C) $display("FAIL wrap_slot1_pc: got %h expected 0000107c", commit_entry[1].pc); else n_pass++;
        n_total++; if (commit_entry[2].pc !== 32'h0000_1000) $display("FAIL wrap_slot2_pc: got %h expected 00001000", commit_entry[2].pc); else n_pass++;
        n_total++; if (commit_entry[3].pc !== 32'h0000_1004) $display("FAIL wrap_slot3_pc: got %h expected 00001004", commit_entry[3].pc); else n_pass++;
        n_total++; if (instret !== 64'd10) $display("FAIL wrap_instret: got %0d expected 10", instret); else n_pass++;
    endtask

    task automatic test_full_width_cap();
        rs.rob_full   = 1'b1;
        rs.rob_head   = 32'h0010_0000;
        rs.rob_finish = 32'h03F0_0000;
        #1;
        n_total++; if (rs.retire_num !== 5'd4) $display("FAIL full_retire_num: got %0d expected 4", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        rs.rob_full   = 1'b0;
        n_total++; if (instret !== 64'd14) $display("FAIL full_instret: got %0d expected 14", instret); else n_pass++;
    endtask

    task automatic test_exception();
        rs.rob[6].pc        = 32'h0000_1040;
        rs.rob[6].exception = 1'b1;
        rs.rob_head         = 32'h0000_0020;
        rs.rob_finish       = 32'h0000_00E0;
        #1;
        n_total++; if (rs.retire_num !== 5'd1) $display("FAIL exc_retire_num: got %0d expected 1", rs.retire_num); else n_pass++;
        step();
        rs.rob_head = 32'h0000_0040;
        n_total++; if (flush !== 1'b1) $display("FAIL exc_flush: got %b expected 1", flush); else n_pass++;
        n_total++; if (redirect_pc !== 32'h0000_1040) $display("FAIL exc_redirect_pc: got %h expected 00001040", redirect_pc); else n_pass++;
        n_total++; if (commit_valid !== 4'b0001) $display("FAIL exc_commit_valid: got %b expected 0001", commit_valid); else n_pass++;
        n_total++; if (commit_entry[0].pc !== 32'h0000_1014) $display("FAIL exc_slot0_pc: got %h expected 00001014", commit_entry[0].pc); else n_pass++;
        #1;
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL exc_flush_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        step();
        n_total++; if (flush !== 1'b0) $display("FAIL exc_flush_one_cycle: got %b expected 0", flush); else n_pass++;
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL exc_drain_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        step();
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL exc_drain2_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        rs.rob_empty  = 1'b1;
        rs.rob_finish = 32'h0000_0000;
        step();
        rs.rob_empty        = 1'b0;
        rs.rob[6].exception = 1'b0;
        rs.rob[6].pc        = 32'h0000_1018;
        rs.rob_finish       = 32'h0000_00C0;
        #1;
        n_total++; if (rs.retire_num !== 5'd2) $display("FAIL exc_resume_retire_num: got %0d expected 2", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        n_total++; if (instret !== 64'd17) $display("FAIL exc_instret: got %0d expected 17", instret); else n_pass++;
    endtask

    task automatic test_empty();
        rs.rob_empty  = 1'b1;
        rs.rob_head   = 32'h0000_0001;
        rs.rob_finish = 32'hFFFF_FFFF;
        #1;
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL empty_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        step();
        n_total++; if (commit_valid !== 4'b0000) $display("FAIL empty_commit_valid: got %b expected 0000", commit_valid); else n_pass++;
        n_total++; if (instret !== 64'd17) $display("FAIL empty_instret: got %0d expected 17", instret); else n_pass++;
        rs.rob_empty  = 1'b0;
        rs.rob_finish = 32'h0000_0000;
    endtask

    task automatic test_async_reset();
        rs.rob[9].exception = 1'b1;
        rs.rob_head         = 32'h0000_0100;
        rs.rob_finish       = 32'h0000_0300;
        #1;
        n_total++; if (rs.retire_num !== 5'd1) $display("FAIL ar_retire_num: got %0d expected 1", rs.retire_num); else n_pass++;
        step();
        rs.rob_head = 32'h0000_0200;
        n_total++; if (flush !== 1'b1) $display("FAIL ar_flush: got %b expected 1", flush); else n_pass++;
        step();
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL ar_drain_retire_num: got %0d expected 0", rs.retire_num); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (flush !== 1'b0) $display("FAIL ar_flush_cleared: got %b expected 0", flush); else n_pass++;
        n_total++; if (commit_valid !== 4'b0000) $display("FAIL ar_commit_valid: got %b expected 0000", commit_valid); else n_pass++;
        n_total++; if (instret !== 64'd0) $display("FAIL ar_instret: got %0d expected 0", instret); else n_pass++;
        n_total++; if (redirect_pc !== 32'd0) $display("FAIL ar_redirect_pc: got %h expected 0", redirect_pc); else n_pass++;
        n_total++; if (rs.retire_num !== 5'd0) $display("FAIL ar_retire_num_in_reset: got %0d expected 0", rs.retire_num); else n_pass++;
        #1 rst = 1'b0;
        rs.rob[9].exception = 1'b0;
        rs.rob_finish       = 32'h0000_0200;
        #1;
        n_total++; if (rs.retire_num !== 5'd1) $display("FAIL ar_run_retire_num: got %0d expected 1", rs.retire_num); else n_pass++;
        step();
        rs.rob_finish = 32'h0000_0000;
        n_total++; if (instret !== 64'd1) $display("FAIL ar_run_instret: got %0d expected 1", instret); else n_pass++;
        n_total++; if (commit_entry[0].pc !== 32'h0000_1024) $display("FAIL ar_run_slot0_pc: got %h expected 00001024", commit_entry[0].pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_four_finished();
        test_gap();
        test_wrap();
        test_full_width_cap();
        test_exception();
        test_empty();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/retire_unit.md
# retire_unit

In-order retirement stage on the sink end of `rob_status_if`. Each cycle it scans the reorder buffer from the one-hot head pointer and selects up to `RETIRE_WIDTH` consecutive finished entries. It returns the count to the ROB on `retire_num` and emits registered commit records to the rename map and free list. When the oldest unretired entry carries an exception, it stops retirement and runs a flush/redirect sequence.

## Interface
- `NUM_ROB_ENTRY`, 32, ROB depth; must match the connected `rob_status_if`.
- `ROB_WIDTH`, 5, log2(`NUM_ROB_ENTRY`); width of `retire_num`.
- `RETIRE_WIDTH`, 4, maximum entries retired per cycle; must be ≤ `NUM_ROB_ENTRY`.
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rob_status`  modport `rob_status_if.sink`  -  reads `rob_finish`, `rob`, `rob_head`, `rob_full`, `rob_empty`; drives `retire_num`.
- `commit_valid`  out  `RETIRE_WIDTH`  per-slot commit strobe, registered.
- `commit_entry`  out  `RETIRE_WIDTH` x `ROB_ENTRY_t`  committed ROB entries, slot 0 oldest, registered.
- `flush`  out  1  pipeline flush pulse, registered.
- `redirect_pc`  out  32  PC of the excepting instruction, valid while `flush`=1.
- `instret`  out  64  count of retired instructions.

## Operation
- **Head index:** `head_idx` = binary encoding of one-hot `rob_head`.
  - Slot k examines entry `(head_idx + k) mod NUM_ROB_ENTRY`, with wrap-around.
- **Slot eligibility:** slot k is eligible iff all of the following hold:
  - state = RUN;
  - `rob_empty` = 0;
  - `rob_finish` is set for slots 0..k;
  - no slot 0..k has `exception` = 1.
- **Count:** `retire_num` = number of eligible slots, 0..`RETIRE_WIDTH`.
  - It is combinational from the current status.
  - The ROB advances its head by `retire_num` at the same edge.
- **Exception:** if the first non-eligible slot j is finished with `exception` = 1 (state RUN, not empty):
  - slots 0..j-1 still retire;
  - `redirect_pc` latches `rob[slot j].pc`;
  - state moves to FLUSH at the next edge.
  - The excepting entry is never counted.
- **State machine:**
  - RUN: normal operation. Goes to FLUSH on an exception.
  - FLUSH: lasts exactly one cycle. `flush` = 1 and `retire_num` = 0. Goes to DRAIN.
  - DRAIN: `retire_num` = 0. Waits for `rob_empty` = 1, then goes to RUN.
- **Full ROB:** `rob_full` needs no special handling; retirement proceeds normally.
- **Illegal head:** if `rob_head` is not one-hot, the lowest set bit is used.
  - The assertion `$onehot(rob_head)` is required in simulation.
- **Retire counter:** `instret` += `retire_num` every cycle and wraps modulo 2^64.
- **ROB_ENTRY_t fields used:** `pc[31:0]`, `exception`, `rd_valid`, `rd_arch`, `pd_new`, `pd_old`.
  - All other fields pass through untouched in `commit_entry`.

## Timing
- Status-to-`retire_num` path is combinational, zero cycles.
- `commit_valid` / `commit_entry` appear one cycle after the cycle in which `retire_num` counted them.
  - `commit_valid[k]` = 1 iff k < registered count.
- `flush` is asserted in the cycle after the exception is detected.
  - At that point the excepting entry is still at the ROB head.
- **Reset values** (asynchronous; take effect immediately regardless of `clk`):
  - state = RUN;
  - `commit_valid` = 0, `commit_entry` = 0;
  - `flush` = 0, `redirect_pc` = 0;
  - `instret` = 0.
  - `retire_num` = 0 while `rst` = 1.
- Reset mid-FLUSH or mid-DRAIN returns to RUN and drops any pending commit records.
- **Exception on slot 0:** `retire_num` = 0 that cycle, then FLUSH.
- **Back-to-back exceptions:** impossible, because the ROB is empty before RUN resumes.

## Structure
- `typedef_pkg` holds:
  - `ROB_ENTRY_t`, including the fields above;
  - the state enum `RETIRE_STATE_t` {RUN, FLUSH, DRAIN};
  - the constant `RETIRE_WIDTH_DEFAULT`.
- Sub-module `retire_select`: purely combinational.
  - Takes `head_idx`, `rob_finish`, the exception bits, and state.
  - Produces the eligible-count and the exception-slot index.
- `retire_unit` holds:
  - the one-hot-to-binary encoder;
  - the FSM;
  - the commit registers;
  - `redirect_pc`;
  - `instret`.

## Test plan
- **Four finished:** reset, then `rob_head` = 1<<3, `rob_finish` bits 3..6 set, no exception.
  - `retire_num` = 4.
  - Next cycle `commit_valid` = 4'b1111 with entries 3,4,5,6 in slots 0..3.
  - `instret` = 4.
- **Gap:** head = 1<<10, finish bits 10, 11, 13.
  - `retire_num` = 2; entry 13 is not retired.
- **Wrap:** head = 1<<30, finish bits 30, 31, 0, 1.
  - `retire_num` = 4; slot order 30, 31, 0, 1.
- **Exception:** head = 1<<5, bits 5..7 finished, entry 6 `exception` = 1 with pc = 0x0000_1040.
  - `retire_num` = 1.
  - Next cycle `flush` = 1 and `redirect_pc` = 0x0000_1040.
  - `retire_num` stays 0 until `rob_empty` = 1, then RUN resumes.
- **Empty / asynchronous reset:**
  - `rob_empty` = 1 with stale finish bits gives `retire_num` = 0.
  - Asserting `rst` asynchronously during DRAIN immediately clears `flush`, `commit_valid`, and `instret`; the state reads RUN.
